// File: rtl/gng_pkg.sv
// Shared constants, stage types and the output saturation helper for the
// noise-add datapath that follows the Gaussian noise generator.
package gng_pkg;

    // Sample widths
    localparam int NOISE_W    = 16;
    localparam int SIG_W      = 16;
    localparam int SIGMA_W    = 16;

    // Fractional bits: noise s<16,11>, signal s<16,14>, sigma u<16,15>
    localparam int NOISE_FRAC = 11;
    localparam int SIG_FRAC   = 14;
    localparam int SIGMA_FRAC = 15;

    // noise*sigma carries 26 fractional bits; the signal carries 14
    localparam int SHIFT      = NOISE_FRAC + SIGMA_FRAC - SIG_FRAC;

    // Datapath widths: product s<33,26>, scaled noise s<21,14>, sum s<22,14>
    localparam int PROD_W     = NOISE_W + SIGMA_W + 1;
    localparam int SCL_W      = PROD_W - SHIFT;
    localparam int SUM_W      = SCL_W + 1;

    // Pipeline depth from accept to m_valid
    localparam int STAGES     = 3;

    // Saturation limits of the s<16,14> output, held at sum width
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (SIG_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - SUM_W'(1);

    // Stage-1 register: scaled product paired with its signal sample
    typedef struct packed {
        logic signed [PROD_W-1:0] prod;
        logic signed [SIG_W-1:0]  sig;
    } st1_t;

    // Clamp a sum-width value into the output range
    function automatic logic [SIG_W-1:0] sat_sig(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] c;
        c = v;
        if (v > SAT_MAX)
            c = SAT_MAX;
        else if (v < SAT_MIN)
            c = SAT_MIN;
        return c[SIG_W-1:0];
    endfunction

endpackage

// File: rtl/gng_noise_fifo.sv
// Noise sample FIFO. Register-based storage, head read straight from the
// storage registers, no fall-through. A push while full is taken only when a
// pop frees the head slot in the same cycle; otherwise it is dropped and
// ovf_pulse fires for that cycle.
module gng_noise_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf_pulse
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign full      = (level == (AW+1)'(DEPTH));
    assign empty     = (level == '0);
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign ovf_pulse = push && full && !pop_ok;
    assign rdata     = mem[rd_ptr];

    // Storage write; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    // Pointers and fill count
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/gng_awgn_add.sv
// Adds sigma-scaled Gaussian noise to a signal stream. Noise is buffered in a
// FIFO and paired in order with each accepted signal sample, then scaled,
// rounded, summed and saturated over three stages. A single enable freezes
// the whole pipeline whenever the output is held by the consumer.
module gng_awgn_add
    import gng_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               noise_valid,
    input  logic [NOISE_W-1:0] noise_data,
    input  logic [SIGMA_W-1:0] sigma,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [SIG_W-1:0]   s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [SIG_W-1:0]   m_data,
    output logic [LW-1:0]      noise_level,
    output logic               noise_ovf,
    input  logic               noise_clr
);

    logic [NOISE_W-1:0]       fifo_rdata;
    logic                     fifo_empty;
    logic                     ovf_pulse;
    logic                     en;
    logic                     accept;
    logic [STAGES:1]          vld_pipe;

    st1_t                     st1;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] rnd_c;
    logic signed [SCL_W-1:0]  scl_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic signed [SUM_W-1:0]  sum_q;

    gng_noise_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (NOISE_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (noise_valid),
        .wdata     (noise_data),
        .pop       (accept),
        .rdata     (fifo_rdata),
        .empty     (fifo_empty),
        .level     (noise_level),
        .ovf_pulse (ovf_pulse)
    );

    // Handshake: a held output freezes everything upstream
    assign en      = !(m_valid && !m_ready);
    assign s_ready = en && !fifo_empty;
    assign accept  = s_valid && s_ready;
    assign m_valid = vld_pipe[STAGES];

    // Zero-extend sigma so the multiply stays signed with unsigned scale
    assign prod_c = $signed(fifo_rdata) * $signed({1'b0, sigma});

    // Round half up, then drop the extra fractional bits arithmetically
    assign rnd_c  = st1.prod + PROD_W'(1 << (SHIFT - 1));
    assign scl_c  = rnd_c[PROD_W-1:SHIFT];
    assign sum_c  = {{(SUM_W-SIG_W){st1.sig[SIG_W-1]}}, st1.sig}
                  + {{(SUM_W-SCL_W){scl_c[SCL_W-1]}}, scl_c};

    // Stage valid bits shift only while the pipeline is enabled
    always_ff @(posedge clk) begin
        if (!rstn)
            vld_pipe <= '0;
        else if (en)
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
    end

    // Stage 1: capture product and signal at accept
    always_ff @(posedge clk) begin
        if (en && accept) begin
            st1.prod <= prod_c;
            st1.sig  <= $signed(s_data);
        end
    end

    // Stage 2: rounded noise plus signal at full width
    always_ff @(posedge clk) begin
        if (en && vld_pipe[1])
            sum_q <= sum_c;
    end

    // Stage 3: saturated output register, held during a stall
    always_ff @(posedge clk) begin
        if (!rstn)
            m_data <= '0;
        else if (en && vld_pipe[2])
            m_data <= sat_sig(sum_q);
    end

    // Sticky drop flag; a drop in the clear cycle keeps it set
    always_ff @(posedge clk) begin
        if (!rstn)
            noise_ovf <= 1'b0;
        else if (ovf_pulse)
            noise_ovf <= 1'b1;
        else if (noise_clr)
            noise_ovf <= 1'b0;
    end

endmodule

// File: tb/tb_gng_awgn_add.sv
// Directed bench for gng_awgn_add: reset state, scaling/rounding/saturation
// vectors, empty FIFO, overflow, randomized backpressure stream, mid-stream reset.
module tb_gng_awgn_add;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        noise_valid = 1'b0;
    logic [15:0] noise_data = '0;
    logic [15:0] sigma = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_data;
    logic [3:0]  noise_level;
    logic        noise_ovf;
    logic        noise_clr = 1'b0;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] got_q[$];
    int          stall_bad = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    logic [15:0] nq [100];
    logic [15:0] sq [100];
    logic [15:0] eq [100];
    int          sent = 0;
    bit          done = 1'b0;

    gng_awgn_add #(.FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .noise_valid (noise_valid),
        .noise_data  (noise_data),
        .sigma       (sigma),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .noise_level (noise_level),
        .noise_ovf   (noise_ovf),
        .noise_clr   (noise_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model(input logic [15:0] nz, input logic [15:0] sg,
                                          input logic [15:0] sd);
        longint p, s;
        p = longint'($signed(nz)) * longint'(sg);
        p = (p + 2048) >>> 12;
        s = longint'($signed(sd)) + p;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    // Output monitor and stall-hold tracker, sampled mid-cycle
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) got_q.push_back(m_data);
        if (rstn && prev_stall && m_data !== prev_data) stall_bad++;
        prev_stall = rstn && m_valid && !m_ready;
        prev_data  = m_data;
    end

    task automatic run_one(input string tag, input logic [15:0] nz, input logic [15:0] sg,
                           input logic [15:0] sd, input logic [15:0] exp);
        noise_valid = 1'b1; noise_data = nz; tick; noise_valid = 1'b0;
        chk({tag, "_lvl"}, 32'(noise_level), 32'd1);
        chk({tag, "_rdy"}, 32'(s_ready), 32'd1);
        sigma = sg; s_data = sd; s_valid = 1'b1; tick; s_valid = 1'b0;
        tick;
        chk({tag, "_early"}, 32'(m_valid), 32'd0);
        tick;
        chk({tag, "_vld"}, 32'(m_valid), 32'd1);
        chk({tag, "_data"}, 32'(m_data), 32'(exp));
        tick;
    endtask

    task automatic do_reset;
        rstn = 1'b0; tick; tick; rstn = 1'b1; tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, n0, seen;
        logic [15:0] e;

        // Reset state
        rstn = 1'b0; tick; tick;
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_mdata", 32'(m_data), 32'd0);
        chk("rst_sready", 32'(s_ready), 32'd0);
        chk("rst_level", 32'(noise_level), 32'd0);
        chk("rst_ovf", 32'(noise_ovf), 32'd0);
        rstn = 1'b1; tick;

        // Directed arithmetic vectors
        run_one("unity",    16'h0800, 16'h8000, 16'h0000, 16'h4000);
        run_one("sat_hi",   16'h0800, 16'h8000, 16'h7000, 16'h7FFF);
        run_one("sat_lo",   16'hF800, 16'h8000, 16'h9000, 16'h8000);
        run_one("round_p",  16'h0001, 16'h0800, 16'h0000, 16'h0001);
        run_one("round_n",  16'hFFFF, 16'h0800, 16'h0000, 16'h0000);
        run_one("round_n2", 16'hFFFE, 16'h0800, 16'h0000, 16'hFFFF);
        run_one("half",     16'h0400, 16'h4000, 16'h1234, 16'h2234);

        // Empty FIFO: no accept until noise arrives, then exactly one output
        got_q.delete();
        sigma = 16'h8000; s_data = 16'h0100; s_valid = 1'b1;
        seen = 0;
        repeat (3) begin tick; if (s_ready || m_valid) seen++; end
        chk("empty_stall", 32'(seen), 32'd0);
        noise_valid = 1'b1; noise_data = 16'h0000; tick; noise_valid = 1'b0;
        chk("empty_rdy", 32'(s_ready), 32'd1);
        tick;
        chk("empty_rdy_drop", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        repeat (6) tick;
        chk("empty_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) chk("empty_data", 32'(got_q[0]), 32'h0100);

        // Overflow: 10 pushes into depth 8, first 8 kept in order
        got_q.delete();
        for (int i = 0; i < 10; i++) begin
            noise_valid = 1'b1; noise_data = 16'(16'h0100 * (i + 1)); tick;
        end
        noise_valid = 1'b0;
        chk("ovf_level", 32'(noise_level), 32'd8);
        chk("ovf_flag", 32'(noise_ovf), 32'd1);
        sigma = 16'h8000; s_data = 16'h0000; s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = 0;
            @(negedge clk);
            while (!s_ready && b < 50) begin @(negedge clk); b++; end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        repeat (6) tick;
        chk("ovf_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            e = 16'(32'h0800 * (i + 1));
            chk($sformatf("ovf_out%0d", i), 32'(got_q[i]), 32'(e));
        end
        chk("ovf_sticky", 32'(noise_ovf), 32'd1);
        chk("ovf_drained", 32'(noise_level), 32'd0);
        noise_clr = 1'b1; tick; noise_clr = 1'b0;
        chk("ovf_clr", 32'(noise_ovf), 32'd0);

        // Set wins over clear; push while full is taken when popping
        for (int i = 0; i < 8; i++) begin
            noise_valid = 1'b1; noise_data = 16'h0010; tick;
        end
        noise_clr = 1'b1; tick; noise_clr = 1'b0;
        chk("ovf_set_wins", 32'(noise_ovf), 32'd1);
        s_valid = 1'b1; tick; noise_valid = 1'b0; s_valid = 1'b0;
        chk("full_push_pop", 32'(noise_level), 32'd8);
        repeat (4) tick;
        do_reset;

        // Random backpressure stream against the reference model
        got_q.delete();
        stall_bad = 0;
        sigma = 16'h5A3C;
        for (int i = 0; i < 100; i++) begin
            nq[i] = 16'($urandom_range(0, 16383)) - 16'd8192;
            sq[i] = 16'($urandom);
            eq[i] = model(nq[i], sigma, sq[i]);
        end
        fork
            begin
                int c;
                c = 0;
                while (sent < 100 && c < 5000) begin
                    s_valid = ($urandom_range(0, 3) != 0);
                    s_data  = sq[sent];
                    @(negedge clk);
                    if (s_valid && s_ready) sent++;
                    @(posedge clk); #1;
                    c++;
                end
                s_valid = 1'b0;
                done = 1'b1;
            end
            begin
                int k, c;
                k = 0; c = 0;
                while (k < 100 && c < 5000) begin
                    noise_valid = 1'b0;
                    if (noise_level < 4'd6 && $urandom_range(0, 1) == 1) begin
                        noise_valid = 1'b1; noise_data = nq[k]; k++;
                    end
                    tick;
                    c++;
                end
                noise_valid = 1'b0;
            end
            begin
                while (!done) begin
                    m_ready = ($urandom_range(0, 2) != 0);
                    tick;
                end
                m_ready = 1'b1;
            end
        join
        b = 0;
        while (got_q.size() < 100 && b < 200) begin tick; b++; end
        chk("stream_sent", 32'(sent), 32'd100);
        chk("stream_count", 32'(got_q.size()), 32'd100);
        for (int i = 0; i < 100 && i < got_q.size(); i++)
            chk($sformatf("stream%0d", i), 32'(got_q[i]), 32'(eq[i]));
        chk("stall_hold", 32'(stall_bad), 32'd0);

        // Reset mid-stream discards in-flight samples
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            noise_valid = 1'b1; noise_data = 16'h0800; tick;
        end
        noise_valid = 1'b0;
        sigma = 16'h8000; s_data = 16'h0100; s_valid = 1'b1;
        tick; tick;
        s_valid = 1'b0;
        tick;
        chk("mid_pre_vld", 32'(m_valid), 32'd1);
        rstn = 1'b0; tick;
        chk("mid_rst_vld", 32'(m_valid), 32'd0);
        chk("mid_rst_data", 32'(m_data), 32'd0);
        chk("mid_rst_level", 32'(noise_level), 32'd0);
        rstn = 1'b1;
        n0 = got_q.size();
        seen = 0;
        repeat (6) begin tick; if (m_valid) seen++; end
        chk("mid_no_out", 32'(seen), 32'd0);
        chk("mid_no_q", 32'(got_q.size()), 32'(n0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gng_awgn_add.md
# gng_awgn_add

Downstream consumer of the Gaussian noise generator output (valid-only, s<16,11> samples). Buffers incoming noise in a small FIFO, scales each noise sample by a programmable sigma, adds it to a signal sample received on a valid/ready stream, and emits the saturated noisy sample on a valid/ready output. Sits between the noise generator's interpolation stage and the channel-model datapath. Noise that arrives when the FIFO is full is dropped and flagged.

## Interface

- `FIFO_DEPTH`, 8: noise FIFO depth in samples; power of two, 4..64.
- `clk`  in  1  system clock.
- `rstn`  in  1  one clock; reset is synchronous and active-low.
- `noise_valid`  in  1  noise sample valid; no backpressure is possible.
- `noise_data`  in  16  noise sample, s<16,11>.
- `sigma`  in  16  noise scale, u<16,15>; range 0 to 1.99997.
- `s_valid`  in  1  signal sample valid.
- `s_ready`  out  1  signal sample accepted when `s_valid && s_ready`.
- `s_data`  in  16  signal sample, s<16,14>.
- `m_valid`  out  1  output sample valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  16  noisy sample, s<16,14>, saturated.
- `noise_level`  out  $clog2(FIFO_DEPTH)+1  FIFO fill count.
- `noise_ovf`  out  1  sticky: a noise sample was dropped.
- `noise_clr`  in  1  clears `noise_ovf`.

## Operation

- Noise FIFO: push on `noise_valid`, unless full and not popping in the same cycle. In that case the sample is dropped and `noise_ovf` is set.
- Push while full is accepted when a pop occurs in the same cycle.
- No fall-through: a sample pushed into an empty FIFO is poppable the following cycle.
- Global pipeline enable `en = !(m_valid && !m_ready)`.
- `s_ready = en && !fifo_empty`; it is combinational.
- Accept means `s_valid && s_ready`. On accept, one FIFO pop pairs the head noise sample with `s_data`. Samples pair strictly in order.
- Stage 1: `p = $signed(noise) * $signed({1'b0, sigma})`. The result is s<33,26>. `s_data` and `sigma` are captured at accept.
- Stage 2: `n = (p + 2^11) >>> 12`, arithmetic shift, round half up. The result is s<21,14>. Then `sum = sign_ext(s_data, 22) + sign_ext(n, 22)`.
- Stage 3: saturate `sum` to [-32768, 32767] and register it to `m_data`.
- Per-stage valid bits advance only when `en` is high. Data is held while stalled.
- `noise_ovf`: when set and clear happen in the same cycle, set wins. Otherwise `noise_clr` clears it.

## Timing

- Reset values: `m_valid=0`, `m_data=0`, `s_ready=0`, `noise_level=0`, `noise_ovf=0`. Reset empties the FIFO and all stage valid bits.
- Reset asserted mid-operation discards in-flight samples; none are emitted after reset.
- Latency: a sample accepted at cycle t has `m_valid=1` at t+3 when no stall occurs.
- Throughput: one sample per cycle while the FIFO is non-empty and `m_ready=1`.
- Backpressure: while `m_valid && !m_ready`, the whole pipeline freezes and `s_ready=0`. The noise FIFO keeps accepting pushes during the stall.
- `noise_level` updates the cycle after a push or pop. Simultaneous push and pop leaves it unchanged.
- `m_data` is stable while `m_valid && !m_ready`.

## Structure

- Shared package `gng_pkg` holds:
  - the width constants NOISE_W=16, SIG_W=16, SIGMA_W=16;
  - the fractional-bit constants NOISE_FRAC=11, SIG_FRAC=14, SIGMA_FRAC=15;
  - the derived SHIFT=12;
  - the saturation limits.
- Sub-module `gng_noise_fifo`: synchronous FIFO with registered read data, full/empty, level, and drop-on-full with overflow pulse.
- The top level contains the 3-stage pipeline, handshake logic and the sticky flag.

## Test plan

- Unity scaling: `sigma=16'h8000`, noise `16'h0800` (1.0), `s_data=16'h0000` → `m_data=16'h4000`, 3 cycles after accept.
- Saturation:
  - `s_data=16'h7000`, noise `16'h0800`, `sigma=16'h8000` → `16'h7FFF`.
  - `s_data=16'h9000`, noise `16'hF800` → `16'h8000`.
- Rounding with `sigma=16'h0800`:
  - noise `16'h0001` → n=1, so `s_data=0` gives `m_data=16'h0001`.
  - noise `16'hFFFF` → n=0, so `m_data=16'h0000`.
- Empty FIFO: `s_valid=1` with no noise → `s_ready=0` and no output. Then one noise pulse → `s_ready=1` the next cycle, and exactly one output.
- Overflow: 10 consecutive noise pulses with `s_valid=0` and depth 8 →
  - `noise_level=8` and `noise_ovf=1`;
  - the next 8 outputs use the first 8 noise samples in order;
  - a `noise_clr` pulse then gives `noise_ovf=0`.
- Backpressure and reset:
  - random `m_ready` toggling over a 100-sample stream → no loss or duplication, and the output matches the reference model in order;
  - `rstn=0` mid-stream → the next cycle shows `m_valid=0`, `m_data=0` and `noise_level=0`.
